alu_arbiter: RTL

Shares the single `alu` instance between two requesters: req0, the execute stage, and req1, the address/CSR helper. It uses valid/ready handshakes on both sides. It arbitrates issue slots, drives the ALU operand and opcode inputs, and uses the ALU `clk_en_i` to hold the ALU's registered result under response backpressure. Registered results return on one shared response channel, tagged with the originating requester ID.

---
 rtl/alu_arbiter_if.sv | 79 +++++++
 rtl/alu_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the request, ALU-side and response signals of alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's.
// Widths come from riscv_defs.v. If that file has not been read first, the defaults
// below describe an RV32 core with a 4-bit ALU opcode.

`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_ALUOP_RANGE
`define RV_ALUOP_RANGE 3:0
`endif

interface alu_arbiter_if;
  logic                   flush_i;

  logic                   req0_valid_i;
  logic                   req0_ready_o;
  logic [`RV_XLEN-1:0]    req0_op_left_i;
  logic [`RV_XLEN-1:0]    req0_op_right_i;
  logic [`RV_ALUOP_RANGE] req0_op_opcode_i;
  logic [`RV_XLEN-1:0]    req0_cmp_left_i;
  logic [`RV_XLEN-1:0]    req0_cmp_right_i;
  logic [2:0]             req0_cmp_opcode_i;

  logic                   req1_valid_i;
  logic                   req1_ready_o;
  logic [`RV_XLEN-1:0]    req1_op_left_i;
  logic [`RV_XLEN-1:0]    req1_op_right_i;
  logic [`RV_ALUOP_RANGE] req1_op_opcode_i;
  logic [`RV_XLEN-1:0]    req1_cmp_left_i;
  logic [`RV_XLEN-1:0]    req1_cmp_right_i;
  logic [2:0]             req1_cmp_opcode_i;

  logic                   alu_clk_en_o;
  logic [`RV_XLEN-1:0]    alu_op_left_o;
  logic [`RV_XLEN-1:0]    alu_op_right_o;
  logic [`RV_ALUOP_RANGE] alu_op_opcode_o;
  logic [`RV_XLEN-1:0]    alu_cmp_left_o;
  logic [`RV_XLEN-1:0]    alu_cmp_right_o;
  logic [2:0]             alu_cmp_opcode_o;
  logic [`RV_XLEN-1:0]    alu_op_result_i;
  logic                   alu_cmp_result_i;

  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic                   rsp_id_o;
  logic [`RV_XLEN-1:0]    rsp_result_o;
  logic                   rsp_cmp_o;

  modport slave (
    input  flush_i,
    input  req0_valid_i, req0_op_left_i, req0_op_right_i, req0_op_opcode_i,
    input  req0_cmp_left_i, req0_cmp_right_i, req0_cmp_opcode_i,
    output req0_ready_o,
    input  req1_valid_i, req1_op_left_i, req1_op_right_i, req1_op_opcode_i,
    input  req1_cmp_left_i, req1_cmp_right_i, req1_cmp_opcode_i,
    output req1_ready_o,
    output alu_clk_en_o, alu_op_left_o, alu_op_right_o, alu_op_opcode_o,
    output alu_cmp_left_o, alu_cmp_right_o, alu_cmp_opcode_o,
    input  alu_op_result_i, alu_cmp_result_i,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cmp_o,
    input  rsp_ready_i
  );

  modport master (
    output flush_i,
    output req0_valid_i, req0_op_left_i, req0_op_right_i, req0_op_opcode_i,
    output req0_cmp_left_i, req0_cmp_right_i, req0_cmp_opcode_i,
    input  req0_ready_o,
    output req1_valid_i, req1_op_left_i, req1_op_right_i, req1_op_opcode_i,
    output req1_cmp_left_i, req1_cmp_right_i, req1_cmp_opcode_i,
    input  req1_ready_o,
    input  alu_clk_en_o, alu_op_left_o, alu_op_right_o, alu_op_opcode_o,
    input  alu_cmp_left_o, alu_cmp_right_o, alu_cmp_opcode_o,
    output alu_op_result_i, alu_cmp_result_i,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_cmp_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between the execute stage (req0) and the
// address/CSR helper (req1). A grant in cycle T yields a tagged response in T+1; the
// ALU clock enable freezes the held result while the response is backpressured.
// Build option RV_ALU_ARB_RR_EN: defined selects round-robin arbitration, undefined
// selects fixed priority with req0 always winning.

module alu_arbiter (
  input logic       clk_i,
  input logic       reset_i,
  alu_arbiter_if.slave bus
);

  logic pending_q, pending_d;
  logic pend_id_q, pend_id_d;
`ifdef RV_ALU_ARB_RR_EN
  logic prio_q, prio_d;
`endif

  logic can_issue;
  logic grant0;
  logic grant1;
  logic granted;

  // Grant decision; a new issue is allowed when the ALU output slot frees up this cycle
  always_comb begin
    can_issue = !reset_i && !bus.flush_i && (!pending_q || bus.rsp_ready_i);
`ifdef RV_ALU_ARB_RR_EN
    grant0 = can_issue && bus.req0_valid_i && (!bus.req1_valid_i || !prio_q);
    grant1 = can_issue && bus.req1_valid_i && (!bus.req0_valid_i || prio_q);
`else
    grant0 = can_issue && bus.req0_valid_i;
    grant1 = can_issue && bus.req1_valid_i && !bus.req0_valid_i;
`endif
    granted = grant0 || grant1;
  end

  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;

  // ALU operand mux; req0 fields are driven when idle (the ALU result is then unused)
  always_comb begin
    bus.alu_op_left_o    = bus.req0_op_left_i;
    bus.alu_op_right_o   = bus.req0_op_right_i;
    bus.alu_op_opcode_o  = bus.req0_op_opcode_i;
    bus.alu_cmp_left_o   = bus.req0_cmp_left_i;
    bus.alu_cmp_right_o  = bus.req0_cmp_right_i;
    bus.alu_cmp_opcode_o = bus.req0_cmp_opcode_i;
    if (grant1) begin
      bus.alu_op_left_o    = bus.req1_op_left_i;
      bus.alu_op_right_o   = bus.req1_op_right_i;
      bus.alu_op_opcode_o  = bus.req1_op_opcode_i;
      bus.alu_cmp_left_o   = bus.req1_cmp_left_i;
      bus.alu_cmp_right_o  = bus.req1_cmp_right_i;
      bus.alu_cmp_opcode_o = bus.req1_cmp_opcode_i;
    end
  end

  // The ALU registers must hold only while an unaccepted result is outstanding
  assign bus.alu_clk_en_o = !pending_q || bus.rsp_ready_i || bus.flush_i;

  // Response channel: the held result is read straight off the ALU registers
  assign bus.rsp_valid_o  = pending_q;
  assign bus.rsp_id_o     = pend_id_q;
  assign bus.rsp_result_o = bus.alu_op_result_i;
  assign bus.rsp_cmp_o    = bus.alu_cmp_result_i;

  // Next-state: flush beats a new grant, which beats a plain response acceptance
  always_comb begin
    pending_d = pending_q;
    pend_id_d = pend_id_q;
`ifdef RV_ALU_ARB_RR_EN
    prio_d    = prio_q;
`endif
    if (bus.flush_i) begin
      pending_d = 1'b0;
    end else if (granted) begin
      pending_d = 1'b1;
      pend_id_d = grant1;
`ifdef RV_ALU_ARB_RR_EN
      prio_d    = !grant1;
`endif
    end else if (pending_q && bus.rsp_ready_i) begin
      pending_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= 1'b0;
      pend_id_q <= 1'b0;
`ifdef RV_ALU_ARB_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      pending_q <= pending_d;
      pend_id_q <= pend_id_d;
`ifdef RV_ALU_ARB_RR_EN
      prio_q    <= prio_d;
`endif
    end
  end

endmodule
